// File: rtl/complex_mult_pkg.sv
// Shared constants for the complex multiplier dispatcher slice.
//   CM_DATA_WIDTH / CM_RES_WIDTH : default operand and result part widths
//   CM_N_INST                    : number of multiplier instances served
//   inst_e                       : instance index (m0 / m1)
package complex_mult_pkg;

  localparam int unsigned CM_DATA_WIDTH = 8;
  localparam int unsigned CM_RES_WIDTH  = 2 * CM_DATA_WIDTH + 2;
  localparam int unsigned CM_N_INST     = 2;

  typedef enum logic {
    INST_M0 = 1'b0,
    INST_M1 = 1'b1
  } inst_e;

  function automatic inst_e other_inst(inst_e i);
    return (i == INST_M0) ? INST_M1 : INST_M0;
  endfunction

endpackage

// File: rtl/complex_mult_watchdog.sv
// Per-instance hold-time watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear
//   start    : operation dispatched to this instance (restarts the count)
//   active   : operation in flight at this instance
//   expired  : pulses during the TIMEOUT_CYCLES-th in-flight cycle
module complex_mult_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of completed in-flight cycles, so the current
  // cycle is the TIMEOUT_CYCLES-th one when cnt_q == TIMEOUT_CYCLES-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || start) begin
      cnt_d = '0;
    end else if (active && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    expired = active & ~clr & (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/complex_mult_dispatcher.sv
// Dispatches one operand stream across two complex multipliers (m0, m1)
// and returns results in issue order.
//   Upstream  : op_val/op_ready, op_1_re/im, op_2_re/im
//   Consumer  : res_val/res_ready, res_re/im (registered)
//   Instances : m_op_val/m_op_ready, broadcast m_op_*, m_res_val/m_res_ready,
//               m0_res_*/m1_res_*
//   Status    : err_timeout, err_spurious (sticky until rst/sw_rst)
module complex_mult_dispatcher
  import complex_mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = CM_DATA_WIDTH,
  parameter int unsigned RES_WIDTH      = 2 * DATA_WIDTH + 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst,
  input  logic                  op_val,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_1_re,
  input  logic [DATA_WIDTH-1:0] op_1_im,
  input  logic [DATA_WIDTH-1:0] op_2_re,
  input  logic [DATA_WIDTH-1:0] op_2_im,
  output logic                  res_val,
  input  logic                  res_ready,
  output logic [RES_WIDTH-1:0]  res_re,
  output logic [RES_WIDTH-1:0]  res_im,
  output logic                  err_timeout,
  output logic                  err_spurious,
  output logic [1:0]            m_op_val,
  input  logic [1:0]            m_op_ready,
  output logic [DATA_WIDTH-1:0] m_op_1_re,
  output logic [DATA_WIDTH-1:0] m_op_1_im,
  output logic [DATA_WIDTH-1:0] m_op_2_re,
  output logic [DATA_WIDTH-1:0] m_op_2_im,
  input  logic [1:0]            m_res_val,
  output logic [1:0]            m_res_ready,
  input  logic [RES_WIDTH-1:0]  m0_res_re,
  input  logic [RES_WIDTH-1:0]  m0_res_im,
  input  logic [RES_WIDTH-1:0]  m1_res_re,
  input  logic [RES_WIDTH-1:0]  m1_res_im
);

  inst_e                     disp_ptr_q, disp_ptr_d;
  inst_e                     coll_ptr_q, coll_ptr_d;
  logic [CM_N_INST-1:0]      inflight_q, inflight_d;
  logic                      res_val_q, res_val_d;
  logic [RES_WIDTH-1:0]      res_re_q, res_re_d;
  logic [RES_WIDTH-1:0]      res_im_q, res_im_d;
  logic                      err_timeout_q, err_timeout_d;
  logic                      err_spurious_q, err_spurious_d;

  logic                      load_allowed;
  logic                      dispatch;
  logic                      collect;
  logic [CM_N_INST-1:0]      dispatch_vec;
  logic [CM_N_INST-1:0]      spurious_vec;
  logic [CM_N_INST-1:0]      wd_expired;
  logic [RES_WIDTH-1:0]      coll_re;
  logic [RES_WIDTH-1:0]      coll_im;

  assign m_op_1_re = op_1_re;
  assign m_op_1_im = op_1_im;
  assign m_op_2_re = op_2_re;
  assign m_op_2_im = op_2_im;

  assign res_val      = res_val_q;
  assign res_re       = res_re_q;
  assign res_im       = res_im_q;
  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;

  always_comb begin
    load_allowed = ~res_val_q | res_ready;

    op_ready = m_op_ready[disp_ptr_q] & ~inflight_q[disp_ptr_q];
    dispatch = op_val & op_ready;

    m_op_val               = '0;
    m_op_val[disp_ptr_q]   = op_val & ~inflight_q[disp_ptr_q];
    dispatch_vec           = '0;
    dispatch_vec[disp_ptr_q] = dispatch;

    collect      = inflight_q[coll_ptr_q] & m_res_val[coll_ptr_q] & load_allowed;
    spurious_vec = m_res_val & ~inflight_q;

    // Collect needs inflight, draining needs ~inflight, so the two never
    // target the same bit.
    m_res_ready             = spurious_vec;
    m_res_ready[coll_ptr_q] = m_res_ready[coll_ptr_q] | collect;

    coll_re = (coll_ptr_q == INST_M1) ? m1_res_re : m0_res_re;
    coll_im = (coll_ptr_q == INST_M1) ? m1_res_im : m0_res_im;

    disp_ptr_d     = disp_ptr_q;
    coll_ptr_d     = coll_ptr_q;
    inflight_d     = inflight_q;
    res_val_d      = res_val_q;
    res_re_d       = res_re_q;
    res_im_d       = res_im_q;
    err_timeout_d  = err_timeout_q | (|wd_expired);
    err_spurious_d = err_spurious_q | (|spurious_vec);

    if (dispatch) begin
      inflight_d[disp_ptr_q] = 1'b1;
      disp_ptr_d             = other_inst(disp_ptr_q);
    end

    if (collect) begin
      inflight_d[coll_ptr_q] = 1'b0;
      coll_ptr_d             = other_inst(coll_ptr_q);
      res_val_d              = 1'b1;
      res_re_d               = coll_re;
      res_im_d               = coll_im;
    end else if (res_ready) begin
      res_val_d = 1'b0;
    end

    if (sw_rst) begin
      disp_ptr_d     = INST_M0;
      coll_ptr_d     = INST_M0;
      inflight_d     = '0;
      res_val_d      = 1'b0;
      res_re_d       = '0;
      res_im_d       = '0;
      err_timeout_d  = 1'b0;
      err_spurious_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ptr_q     <= INST_M0;
      coll_ptr_q     <= INST_M0;
      inflight_q     <= '0;
      res_val_q      <= 1'b0;
      res_re_q       <= '0;
      res_im_q       <= '0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      disp_ptr_q     <= disp_ptr_d;
      coll_ptr_q     <= coll_ptr_d;
      inflight_q     <= inflight_d;
      res_val_q      <= res_val_d;
      res_re_q       <= res_re_d;
      res_im_q       <= res_im_d;
      err_timeout_q  <= err_timeout_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  for (genvar g = 0; g < CM_N_INST; g++) begin : g_wd
    complex_mult_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
      .clk    (clk),
      .rst    (rst),
      .clr    (sw_rst),
      .start  (dispatch_vec[g]),
      .active (inflight_q[g]),
      .expired(wd_expired[g])
    );
  end

endmodule

// File: doc/complex_mult_dispatcher.md
Name: complex_mult_dispatcher

Overview:
Schedules a single upstream operand stream across two complex multiplier instances (m0, m1). Returns results upstream strictly in issue order. Sits between the operand producer/result consumer and the two multiplier instances, using the same op_val/op_ready and res_val/res_ready handshake on both sides. Doubles throughput when each multiplier holds its result until it is consumed. Also detects stuck or misbehaving instances.

Parameters:
DATA_WIDTH, 8, width of each operand part (re/im)
RES_WIDTH, 2*DATA_WIDTH+2, width of each result part as produced by the multiplier instances
TIMEOUT_CYCLES, 64, maximum cycles an instance may hold an issued operation before err_timeout is raised (must be >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
sw_rst  in  1  synchronous software clear, active 1; same effect as rst
op_val  in  1  upstream operands valid
op_ready  out  1  dispatcher accepts operands this cycle
op_1_re, op_1_im, op_2_re, op_2_im  in  DATA_WIDTH each  upstream operands
res_val  out  1  result valid toward consumer
res_ready  in  1  consumer accepts result
res_re, res_im  out  RES_WIDTH each  result toward consumer
err_timeout  out  1  sticky: an instance exceeded TIMEOUT_CYCLES
err_spurious  out  1  sticky: an instance asserted res_val with no operation in flight
m_op_val  out  2  per-instance operand valid (bit i = instance i)
m_op_ready  in  2  per-instance ready
m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im  out  DATA_WIDTH each  operands broadcast to both instances
m_res_val  in  2  per-instance result valid
m_res_ready  out  2  per-instance result accept
m0_res_re, m0_res_im, m1_res_re, m1_res_im  in  RES_WIDTH each  instance results

Behaviour:
- State: disp_ptr (1b), coll_ptr (1b), inflight[1:0], out register (res_val, res_re, res_im), per-instance watchdog counters, two sticky error flags.
- Reset (rst async, or sw_rst sync): all state and registered outputs go to 0. This covers res_val=0, res_re=res_im=0, err_*=0, disp_ptr=coll_ptr=0, inflight=0. Operations in flight are abandoned; results later produced by an instance for those operations count as spurious.
- Operand broadcast: m_op_* = op_* combinationally.
- Dispatch (combinational): op_ready = m_op_ready[disp_ptr] & ~inflight[disp_ptr]. m_op_val[i] = op_val & (disp_ptr==i) & ~inflight[i].
- Dispatch handshake: op_val & op_ready at a rising edge sets inflight[disp_ptr] and toggles disp_ptr. When both instances are in flight, op_ready=0.
- Output register: a load is allowed when res_val==0, or when res_val & res_ready in the same cycle (full throughput, one result per cycle).
- Collect: m_res_ready[coll_ptr] = inflight[coll_ptr] & m_res_val[coll_ptr] & load_allowed. The other bit is 0, except that a spurious result is drained (see below).
- On a collect, the output register captures that instance's re/im and sets res_val=1, inflight[coll_ptr] clears, and coll_ptr toggles.
- Latency: one cycle from the instance handshake to res_val.
- Ordering: results leave in issue order. An instance finishing early waits while the other instance's older result is pending.
- Simultaneous events: dispatch to one instance and collect from the other in the same cycle are both performed. The same instance cannot be both dispatched and collected in one cycle (dispatch requires ~inflight, collect requires inflight).
- Consumer stall: res_val & ~res_ready holds res_re/res_im stable and blocks further collects.
- Watchdog: the counter of instance i resets to 0 on dispatch and increments while inflight[i]. Reaching TIMEOUT_CYCLES sets err_timeout. Operation continues. The counter saturates.
- Spurious: m_res_val[i] & ~inflight[i] sets err_spurious, and m_res_ready[i] is driven 1 for that cycle to drain the result, which is discarded.
- Error flags clear only on rst or sw_rst.

Decomposition:
- Shared package (complex_mult_pkg): DATA_WIDTH and RES_WIDTH defaults, instance-count constant (2), index constants for m0/m1.
- One sub-module: complex_mult_watchdog (a single counter plus timeout compare), instantiated twice.
- Dispatch, collect and output-register logic stay in the top module.

Test Plan:
- Single op (2,3,4,5), res_ready held 1 -> goes to m0; res_re=-7, res_im=22 one cycle after m0 res handshake; disp_ptr=1, coll_ptr=1.
- Back-to-back ops (2,3,4,5) then (1,1,1,1), with m1 finishing 5 cycles before m0 -> first result (-7,22), then (0,2); m1 result held until m0's is collected.
- Both instances busy, third op presented -> op_ready=0 until the m0 result is collected; the third op then dispatches to m0.
- res_ready=0 for 10 cycles with a result pending -> res_val and data stable, m_res_ready=0; release -> one transfer per cycle.
- m1 never returns, TIMEOUT_CYCLES=64 -> err_timeout=1 at the 64th in-flight cycle; sw_rst clears it and all state.
- m0 asserts res_val with nothing in flight -> err_spurious=1, m_res_ready[0]=1 for that cycle, res_val remains 0.
- rst asserted mid-operation (both instances in flight) -> all outputs 0 immediately; the next op dispatches to m0.
